// File: rtl/transmissor_serial.sv
// Parallel-in / serial-out frame transmitter: start bit, LSB-first data, optional
// even parity and a stop bit, each held for CICLOS_POR_BIT clock cycles.
module transmissor_serial #(
    parameter int NBITS_DADO     = 4,
    parameter int CICLOS_POR_BIT = 4,
    parameter bit PARIDADE       = 1'b1
) (
    input  logic                  clk_2,
    input  logic                  reset_n,
    input  logic [NBITS_DADO-1:0] dado_in,
    input  logic                  valido_in,
    output logic                  pronto_out,
    output logic                  serial_out,
    output logic                  fim_out,
    output logic [2:0]            estado_out
);

    localparam int CW = (CICLOS_POR_BIT > 1) ? $clog2(CICLOS_POR_BIT) : 1;
    localparam int IW = (NBITS_DADO > 1) ? $clog2(NBITS_DADO) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CICLOS_POR_BIT - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NBITS_DADO - 1);

    typedef enum logic [2:0] {
        ST_OCIOSO   = 3'd0,
        ST_INICIO   = 3'd1,
        ST_DADOS    = 3'd2,
        ST_PARIDADE = 3'd3,
        ST_PARADA   = 3'd4
    } estado_t;

    estado_t               estado_q;
    logic [CW-1:0]         cnt_q;
    logic [IW-1:0]         idx_q;
    logic [NBITS_DADO-1:0] shift_q;
    logic                  par_q;
    logic                  serial_q;
    logic                  fim_q;
    logic [NBITS_DADO-1:0] shift_d;

    // Line value for the next data bit is taken from the already-shifted word.
    assign shift_d = shift_q >> 1;

    always_ff @(posedge clk_2) begin
        if (!reset_n) begin
            // NOTE: the datapath registers are reset as well, so an aborted frame leaves no stale word behind.
            estado_q <= ST_OCIOSO;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            fim_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the pre-edge values of the others.
            fim_q <= 1'b0;
            case (estado_q)
                ST_OCIOSO: begin
                    serial_q <= 1'b1;
                    if (valido_in) begin
                        shift_q  <= dado_in;
                        par_q    <= ^dado_in;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        serial_q <= 1'b0;
                        estado_q <= ST_INICIO;
                    end
                end
                ST_INICIO, ST_DADOS, ST_PARIDADE, ST_PARADA: begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + CW'(1);
                    end else begin
                        cnt_q <= '0;
                        case (estado_q)
                            ST_INICIO: begin
                                serial_q <= shift_q[0];
                                estado_q <= ST_DADOS;
                            end
                            ST_DADOS: begin
                                shift_q <= shift_d;
                                if (idx_q == IDX_MAX) begin
                                    idx_q <= '0;
                                    if (PARIDADE) begin
                                        serial_q <= par_q;
                                        estado_q <= ST_PARIDADE;
                                    end else begin
                                        serial_q <= 1'b1;
                                        estado_q <= ST_PARADA;
                                    end
                                end else begin
                                    idx_q    <= idx_q + IW'(1);
                                    serial_q <= shift_d[0];
                                end
                            end
                            ST_PARIDADE: begin
                                serial_q <= 1'b1;
                                estado_q <= ST_PARADA;
                            end
                            default: begin
                                serial_q <= 1'b1;
                                fim_q    <= 1'b1;
                                estado_q <= ST_OCIOSO;
                            end
                        endcase
                    end
                end
                default: begin
                    serial_q <= 1'b1;
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    estado_q <= ST_OCIOSO;
                end
            endcase
        end
    end

    // Ready drops as soon as reset is asserted so no word is offered to a block being reset.
    assign pronto_out = (estado_q == ST_OCIOSO) && reset_n;
    assign serial_out = serial_q;
    assign fim_out    = fim_q;
    assign estado_out = estado_q;

endmodule

// File: tb/tb_transmissor_serial.sv
// Scoreboard bench for transmissor_serial: one instance with default parameters and
// one with PARIDADE=0, CICLOS_POR_BIT=1; expected line waveforms built from frame rules.
module tb_transmissor_serial;

    typedef struct packed {
        logic       serial;
        logic       fim;
        logic       pronto;
        logic [2:0] est;
    } obs_t;

    localparam obs_t IDLE = '{serial: 1'b1, fim: 1'b0, pronto: 1'b1, est: 3'd0};

    logic       clk;
    logic       rst_a_n, rst_b_n;
    logic [3:0] dado_a, dado_b;
    logic       valido_a, valido_b;
    logic       pr_a, ser_a, fim_a;
    logic       pr_b, ser_b, fim_b;
    logic [2:0] est_a, est_b;
    logic       mon_en;

    obs_t exp_a_q[$];
    obs_t exp_b_q[$];
    int   n_cmp;
    int   n_err;

    transmissor_serial dut_a (
        .clk_2      (clk),
        .reset_n    (rst_a_n),
        .dado_in    (dado_a),
        .valido_in  (valido_a),
        .pronto_out (pr_a),
        .serial_out (ser_a),
        .fim_out    (fim_a),
        .estado_out (est_a)
    );

    transmissor_serial #(
        .NBITS_DADO     (4),
        .CICLOS_POR_BIT (1),
        .PARIDADE       (1'b0)
    ) dut_b (
        .clk_2      (clk),
        .reset_n    (rst_b_n),
        .dado_in    (dado_b),
        .valido_in  (valido_b),
        .pronto_out (pr_b),
        .serial_out (ser_b),
        .fim_out    (fim_b),
        .estado_out (est_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_obs(input bit which, input obs_t o);
        if (which) exp_b_q.push_back(o);
        else       exp_a_q.push_back(o);
    endtask

    // Reference model: a frame is a list of line bits, each repeated for one bit time,
    // followed by one idle cycle carrying the end-of-frame pulse.
    task automatic push_frame(input bit which, input logic [3:0] data);
        int   c;
        bit   par;
        logic bits[$];
        int   cls[$];
        obs_t o;
        c   = which ? 1 : 4;
        par = which ? 1'b0 : 1'b1;
        bits.push_back(1'b0); cls.push_back(1);
        for (int k = 0; k < 4; k++) begin
            bits.push_back(data[k]); cls.push_back(2);
        end
        if (par) begin
            bits.push_back(^data); cls.push_back(3);
        end
        bits.push_back(1'b1); cls.push_back(4);
        for (int i = 0; i < bits.size(); i++) begin
            for (int j = 0; j < c; j++) begin
                o = '{serial: bits[i], fim: 1'b0, pronto: 1'b0, est: 3'(cls[i])};
                push_obs(which, o);
            end
        end
        push_obs(which, '{serial: 1'b1, fim: 1'b1, pronto: 1'b1, est: 3'd0});
    endtask

    task automatic set_in(input bit which, input logic v, input logic [3:0] d);
        if (which) begin
            valido_b = v;
            dado_b   = d;
        end else begin
            valido_a = v;
            dado_a   = d;
        end
    endtask

    task automatic set_valid(input bit which, input logic v);
        if (which) valido_b = v;
        else       valido_a = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in a cycle where the DUT is ready; returns in the frame's first idle cycle.
    task automatic run_frame(input bit which, input logic [3:0] data, input bit keep_valid, input bit noise);
        int n;
        n = which ? 6 : 28;
        set_in(which, 1'b1, data);
        tick();
        push_frame(which, data);
        set_valid(which, keep_valid);
        for (int i = 1; i <= n; i++) begin
            tick();
            if (noise && i >= 5 && i <= 20) set_in(which, 1'($urandom_range(0, 1)), 4'b0000);
            else if (noise) set_valid(which, 1'b0);
        end
    endtask

    task automatic mon_one(input bit which);
        obs_t act;
        obs_t exp;
        exp = IDLE;
        if (which) begin
            act = '{serial: ser_b, fim: fim_b, pronto: pr_b, est: est_b};
            if (exp_b_q.size() > 0) exp = exp_b_q.pop_front();
        end else begin
            act = '{serial: ser_a, fim: fim_a, pronto: pr_a, est: est_a};
            if (exp_a_q.size() > 0) exp = exp_a_q.pop_front();
        end
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got serial=%b fim=%b pronto=%b estado=%0d, expected serial=%b fim=%b pronto=%b estado=%0d",
                     which ? "dut_b" : "dut_a", $time, act.serial, act.fim, act.pronto, act.est,
                     exp.serial, exp.fim, exp.pronto, exp.est);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(1'b0);
            mon_one(1'b1);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        bit         keep;
        n_cmp    = 0;
        n_err    = 0;
        mon_en   = 1'b0;
        rst_a_n  = 1'b0;
        rst_b_n  = 1'b0;
        valido_a = 1'b0;
        valido_b = 1'b0;
        dado_a   = 4'b0000;
        dado_b   = 4'b0000;
        repeat (3) tick();
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
        mon_en  = 1'b1;
        repeat (2) tick();

        // Reset in the middle of a frame: cycles 11 and 12 see the reset state.
        set_in(1'b0, 1'b1, 4'b1011);
        tick();
        push_frame(1'b0, 4'b1011);
        set_valid(1'b0, 1'b0);
        repeat (10) tick();
        rst_a_n = 1'b0;
        while (exp_a_q.size() > 1) void'(exp_a_q.pop_back());
        push_obs(1'b0, '{serial: 1'b1, fim: 1'b0, pronto: 1'b0, est: 3'd0});
        push_obs(1'b0, '{serial: 1'b1, fim: 1'b0, pronto: 1'b0, est: 3'd0});
        repeat (3) tick();
        rst_a_n = 1'b1;
        repeat (40) tick();

        // Single frame, parity corner words, back-to-back pair, busy-ignore.
        run_frame(1'b0, 4'b1011, 1'b0, 1'b0);
        repeat (3) tick();
        run_frame(1'b0, 4'b0000, 1'b0, 1'b0);
        run_frame(1'b0, 4'b1111, 1'b0, 1'b0);
        tick();
        run_frame(1'b0, 4'b0111, 1'b0, 1'b0);
        run_frame(1'b0, 4'b1000, 1'b0, 1'b0);
        repeat (2) tick();
        run_frame(1'b0, 4'b0101, 1'b1, 1'b0);
        run_frame(1'b0, 4'b1010, 1'b0, 1'b0);
        repeat (2) tick();
        run_frame(1'b0, 4'b1011, 1'b0, 1'b1);
        repeat (35) tick();

        // Short frames without parity.
        run_frame(1'b1, 4'b1011, 1'b0, 1'b0);
        repeat (3) tick();

        for (int i = 0; i < 10; i++) begin
            d    = 4'($urandom_range(0, 15));
            keep = (i != 9) && ($urandom_range(0, 1) == 1);
            run_frame(1'b0, d, keep, !keep && ($urandom_range(0, 3) == 0));
            if (!keep) repeat ($urandom_range(0, 3)) tick();
        end
        for (int i = 0; i < 16; i++) begin
            d    = 4'($urandom_range(0, 15));
            keep = (i != 15) && ($urandom_range(0, 1) == 1);
            run_frame(1'b1, d, keep, 1'b0);
            if (!keep) repeat ($urandom_range(0, 3)) tick();
        end
        repeat (10) tick();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
